// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

   localparam int PC_W        = 64;
   localparam int INSTR_W     = 32;
   localparam int INSTR_BYTES = 4;
   localparam int OPCODE_MSB  = 31;
   localparam int OPCODE_LSB  = 21;

endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection: sequential increment or word-scaled branch target.
import ifetch_pkg::*;

module next_pc_calc (
   input  logic [PC_W-1:0] pc,
   input  logic [PC_W-1:0] branch_offset,
   input  logic            branch,
   input  logic            uncond_branch,
   input  logic            alu_zero,
   output logic [PC_W-1:0] next_pc,
   output logic            taken
);

   logic [PC_W-1:0] seq_pc;
   logic [PC_W-1:0] target_pc;

   // Offsets are in words; both sums wrap silently modulo 2^64.
   always_comb begin
      taken     = uncond_branch | (branch & alu_zero);
      seq_pc    = pc + PC_W'(INSTR_BYTES);
      target_pc = pc + {branch_offset[PC_W-3:0], 2'b00};
      next_pc   = taken ? target_pc : seq_pc;
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, req/ack imem port, valid/ready hand-off to decode.
// Optional perf counters are enabled with `define IFETCH_PERF_CNT_EN.
import ifetch_pkg::*;

module instr_fetch_unit #(
   parameter logic [63:0] RESET_PC    = 64'h0,
   parameter int          ACK_TIMEOUT = 16,
   parameter int          TO_W        = 5
) (
   input  logic                CLK,
   input  logic                resetl,
   output logic                imem_req,
   output logic [PC_W-1:0]     imem_addr,
   input  logic                imem_ack,
   input  logic [INSTR_W-1:0]  imem_rdata,
   output logic                instr_valid,
   input  logic                instr_ready,
   output logic [INSTR_W-1:0]  instr,
   output logic [10:0]         opcode,
   output logic [PC_W-1:0]     pc,
   input  logic                branch,
   input  logic                uncond_branch,
   input  logic                alu_zero,
   input  logic [PC_W-1:0]     branch_offset,
`ifdef IFETCH_PERF_CNT_EN
   output logic [31:0]         retired_cnt,
   output logic [31:0]         taken_cnt,
`endif
   output logic                fetch_err
);

   fetch_state_e        state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INSTR_W-1:0]  instr_q, instr_d;
   logic                req_en_q, req_en_d;
   logic                fetch_err_q, fetch_err_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [PC_W-1:0]     next_pc;
   logic                taken;
   logic                fire;

`ifdef IFETCH_PERF_CNT_EN
   logic [31:0]         retired_cnt_q, retired_cnt_d;
   logic [31:0]         taken_cnt_q, taken_cnt_d;
`endif

   next_pc_calc u_next_pc_calc (
      .pc            (pc_q),
      .branch_offset (branch_offset),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .alu_zero      (alu_zero),
      .next_pc       (next_pc),
      .taken         (taken)
   );

   // req_en_q keeps the request low during reset and drops it asynchronously.
   assign imem_req    = req_en_q & (state_q == FETCH);
   assign imem_addr   = pc_q;
   assign instr_valid = (state_q == HOLD);
   assign fire        = instr_valid & instr_ready;
   assign instr       = instr_q;
   assign opcode      = instr_q[OPCODE_MSB:OPCODE_LSB];
   assign pc          = pc_q;
   assign fetch_err   = fetch_err_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      instr_d     = instr_q;
      req_en_d    = 1'b1;
      fetch_err_d = fetch_err_q;
      to_cnt_d    = to_cnt_q;
      case (state_q)
         FETCH: begin
            if (imem_req) begin
               if (imem_ack) begin
                  instr_d  = imem_rdata;
                  state_d  = HOLD;
                  to_cnt_d = '0;
               end else begin
                  // Saturating wait counter; the error stays set until reset.
                  if (to_cnt_q != TO_W'(ACK_TIMEOUT)) begin
                     to_cnt_d = to_cnt_q + TO_W'(1);
                  end
                  if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                     fetch_err_d = 1'b1;
                  end
               end
            end
         end
         HOLD: begin
            if (fire) begin
               pc_d    = next_pc;
               state_d = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         instr_q     <= '0;
         req_en_q    <= 1'b0;
         fetch_err_q <= 1'b0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_q     <= instr_d;
         req_en_q    <= req_en_d;
         fetch_err_q <= fetch_err_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

`ifdef IFETCH_PERF_CNT_EN
   always_comb begin
      retired_cnt_d = retired_cnt_q;
      taken_cnt_d   = taken_cnt_q;
      if (fire) begin
         retired_cnt_d = retired_cnt_q + 32'd1;
         if (taken) begin
            taken_cnt_d = taken_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge resetl) begin
      if (!resetl) begin
         retired_cnt_q <= '0;
         taken_cnt_q   <= '0;
      end else begin
         retired_cnt_q <= retired_cnt_d;
         taken_cnt_q   <= taken_cnt_d;
      end
   end

   assign retired_cnt = retired_cnt_q;
   assign taken_cnt   = taken_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: fetches, branches, stalls, timeout, reset.
module tb_instr_fetch_unit;

   localparam int ACK_TIMEOUT = 16;
   localparam int TO_W        = 5;

   logic        CLK = 1'b0;
   logic        resetl;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [10:0] opcode;
   logic [63:0] pc;
   logic        branch;
   logic        uncond_branch;
   logic        alu_zero;
   logic [63:0] branch_offset;
   logic        fetch_err;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] retired_cnt;
   logic [31:0] taken_cnt;
   logic [31:0] expRetired;
   logic [31:0] expTaken;
`endif

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        expQ[$];
   int          checkCount = 0;
   int          errorCount = 0;
   logic [63:0] modelPc;
   logic        expErr;

   always #5 CLK = ~CLK;

   instr_fetch_unit #(
      .RESET_PC    (64'h0),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .TO_W        (TO_W)
   ) dut (
      .CLK           (CLK),
      .resetl        (resetl),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr         (instr),
      .opcode        (opcode),
      .pc            (pc),
      .branch        (branch),
      .uncond_branch (uncond_branch),
      .alu_zero      (alu_zero),
      .branch_offset (branch_offset),
`ifdef IFETCH_PERF_CNT_EN
      .retired_cnt   (retired_cnt),
      .taken_cnt     (taken_cnt),
`endif
      .fetch_err     (fetch_err)
   );

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete fetch: wait for request, ack after ackDelay cycles, check the
   // held instruction against the scoreboard, stall holdCycles, then fire.
   task automatic applyStimulus(input logic [31:0] rdata, input int ackDelay,
                                input logic br, input logic ubr, input logic zero,
                                input logic [63:0] off, input int holdCycles);
      exp_t e;
      logic tk;
      int   w;
      w = 0;
      while (!imem_req && w < 50) begin
         @(negedge CLK);
         w++;
      end
      checkOutput("req_seen", imem_req, 64'd1);
      checkOutput("imem_addr", imem_addr, modelPc);
      for (int i = 0; i < ackDelay; i++) begin
         @(negedge CLK);
         if (i + 1 == ACK_TIMEOUT - 1) checkOutput("err_before_timeout", fetch_err, expErr);
         if (i + 1 == ACK_TIMEOUT) expErr = 1'b1;
      end
      if (ackDelay > 0) begin
         checkOutput("req_while_waiting", imem_req, 64'd1);
         checkOutput("err_after_wait", fetch_err, expErr);
      end
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      e.pc       = modelPc;
      e.instr    = rdata;
      expQ.push_back(e);
      @(negedge CLK);
      imem_ack   = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      w = 0;
      while (!instr_valid && w < 50) begin
         @(negedge CLK);
         w++;
      end
      checkOutput("instr_valid", instr_valid, 64'd1);
      if (expQ.size() > 0) begin
         e = expQ.pop_front();
         checkOutput("held_pc", pc, e.pc);
         checkOutput("held_instr", instr, e.instr);
         checkOutput("opcode", opcode, e.instr[31:21]);
      end
      checkOutput("req_in_hold", imem_req, 64'd0);
      checkOutput("fetch_err", fetch_err, expErr);
      for (int i = 0; i < holdCycles; i++) begin
         imem_ack    = 1'b1;
         imem_rdata  = $urandom;
         instr_ready = 1'b0;
         @(negedge CLK);
         checkOutput("stall_instr", instr, e.instr);
         checkOutput("stall_pc", pc, e.pc);
         checkOutput("stall_valid", instr_valid, 64'd1);
         checkOutput("stall_req", imem_req, 64'd0);
      end
      imem_ack      = 1'b0;
      branch        = br;
      uncond_branch = ubr;
      alu_zero      = zero;
      branch_offset = off;
      instr_ready   = 1'b1;
      tk = ubr | (br & zero);
      @(negedge CLK);
      instr_ready   = 1'b0;
      branch        = 1'b0;
      uncond_branch = 1'b0;
      alu_zero      = 1'b0;
      branch_offset = '0;
      modelPc = tk ? modelPc + {off[61:0], 2'b00} : modelPc + 64'd4;
`ifdef IFETCH_PERF_CNT_EN
      expRetired++;
      if (tk) expTaken++;
`endif
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [63:0] off;
      resetl        = 1'b0;
      imem_ack      = 1'b0;
      imem_rdata    = '0;
      instr_ready   = 1'b0;
      branch        = 1'b0;
      uncond_branch = 1'b0;
      alu_zero      = 1'b0;
      branch_offset = '0;
      modelPc       = 64'h0;
      expErr        = 1'b0;
`ifdef IFETCH_PERF_CNT_EN
      expRetired    = '0;
      expTaken      = '0;
`endif
      repeat (3) @(negedge CLK);
      checkOutput("rst_req", imem_req, 64'd0);
      checkOutput("rst_valid", instr_valid, 64'd0);
      checkOutput("rst_pc", pc, 64'h0);
      checkOutput("rst_instr", instr, 64'h0);
      checkOutput("rst_err", fetch_err, 64'd0);
      resetl = 1'b1;
      #1;
      checkOutput("req_before_first_edge", imem_req, 64'd0);
      @(negedge CLK);
      checkOutput("req_first_cycle", imem_req, 64'd1);

      // Reset release, single-cycle fetch
      applyStimulus(32'h8B02_0020, 0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
      checkOutput("t1_opcode", opcode, 64'h458);
      checkOutput("t1_next_addr", imem_addr, 64'h4);
      for (int i = 0; i < 3; i++) applyStimulus($urandom, i % 2, 1'b0, 1'b0, 1'b0, 64'h0, 0);

      // Conditional branch taken / not taken at 0x10
      applyStimulus($urandom, 1, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      checkOutput("t2_taken_addr", imem_addr, 64'h08);
      for (int i = 0; i < 2; i++) applyStimulus($urandom, 0, 1'b0, 1'b0, 1'b0, 64'h0, 0);
      applyStimulus($urandom, 0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      checkOutput("t2_not_taken_addr", imem_addr, 64'h14);
      for (int i = 0; i < 3; i++) applyStimulus($urandom, 2, 1'b0, 1'b0, 1'b0, 64'h0, 0);

      // Unconditional branch dominates an unknown branch control
      applyStimulus($urandom, 0, 1'bx, 1'b1, 1'b0, 64'h3, 0);
      checkOutput("t3_uncond_addr", imem_addr, 64'h2C);

      // Stall in HOLD with spurious acks
      applyStimulus(32'h1234_5678, 0, 1'b0, 1'b0, 1'b0, 64'h0, 5);
      checkOutput("t4_next_addr", imem_addr, 64'h30);

      // Ack timeout, then late completion
      applyStimulus(32'hCAFE_F00D, ACK_TIMEOUT + 3, 1'b0, 1'b0, 1'b0, 64'h0, 0);
      checkOutput("t5_err_sticky", fetch_err, 64'd1);
      for (int i = 0; i < 3; i++) applyStimulus($urandom, 0, 1'b0, 1'b0, 1'b0, 64'h0, 0);

      // Reset mid-fetch at 0x40 with a stale ack
      checkOutput("t6_addr_before_rst", imem_addr, 64'h40);
      @(negedge CLK);
      resetl = 1'b0;
      #1;
      checkOutput("t6_req_async_drop", imem_req, 64'd0);
      checkOutput("t6_pc_reset", pc, 64'h0);
      checkOutput("t6_err_cleared", fetch_err, 64'd0);
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_BAD0;
      @(negedge CLK);
      resetl  = 1'b1;
      modelPc = 64'h0;
      expErr  = 1'b0;
      expQ.delete();
`ifdef IFETCH_PERF_CNT_EN
      expRetired = '0;
      expTaken   = '0;
`endif
      @(negedge CLK);
      checkOutput("t6_stale_ack_valid", instr_valid, 64'd0);
      checkOutput("t6_stale_ack_instr", instr, 64'h0);
      imem_ack = 1'b0;
      applyStimulus(32'h9100_0421, 0, 1'b0, 1'b0, 1'b0, 64'h0, 0);

      // Wrap-around: jump to the last word, then step past it
      off = ~(modelPc >> 2);
      applyStimulus($urandom, 0, 1'b0, 1'b1, 1'b0, off, 0);
      checkOutput("wrap_top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      applyStimulus($urandom, 1, 1'b0, 1'b0, 1'b0, 64'h0, 0);
      checkOutput("wrap_zero_addr", imem_addr, 64'h0);
      checkOutput("pc_aligned", {62'd0, imem_addr[1:0]}, 64'h0);

`ifdef IFETCH_PERF_CNT_EN
      checkOutput("retired_cnt", retired_cnt, expRetired);
      checkOutput("taken_cnt", taken_cnt, expTaken);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
